inst_display_scan: RTL
======================

Name: inst_display_scan

Overview:
- Downstream consumer of the 40-bit instruction word from the instruction generators, e.g. the "BALANCE" scroller.
- The word is eight 5-bit character codes. Character [39:35] is the leftmost digit and [4:0] the rightmost.
- The block snapshots the word once per frame and time-multiplexes it onto an 8-digit common-anode 7-segment display.
- It adds a guard (blanking) interval between digits to suppress ghosting, and pulses frame_done at the end of each frame.

Parameters:
- SCAN_DIV, 100000: sys_clock cycles per digit slot. Legal values: SCAN_DIV >= GUARD_CYCLES+2.
- GUARD_CYCLES, 1000: cycles at the start of each slot with all anodes off.

Ports:
- sys_clock  input  1  single system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- instruction  input  40  eight 5-bit character codes; [39:35] = digit 7 (leftmost).
- enable  input  1  1 = scan the display; 0 = blank it.
- an  output  8  digit anodes, active-low; an[7] = leftmost.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- frame_done  output  1  one-cycle pulse when the digit-0 slot completes.

Behaviour:
- Reset (asynchronous on reset_n low):
  - an=8'hFF, seg=7'h7F, frame_done=0.
  - state=IDLE, slot counter=0, digit index=7, snapshot=0.
- All outputs are registered. No combinational path from any input to any output.
- FSM states:
  - IDLE: an=FF, seg=7F. Go to SCAN when enable=1. On that transition, snapshot<=instruction, digit=7, counter=0.
  - SCAN: the slot counter runs 0..SCAN_DIV-1.
    - At count 0, seg is loaded with the decode of the snapshot character for the current digit.
    - For count < GUARD_CYCLES, an=FF.
    - For count >= GUARD_CYCLES, an = one-hot-low on the current digit.
    - At count SCAN_DIV-1, counter wraps to 0 and the digit decrements.
    - When digit 0 ends: frame_done=1 for that one cycle, digit wraps to 7, and snapshot<=instruction on the same edge.
  - enable=0 in SCAN: next edge goes to IDLE, an=FF, seg=7F, counter=0. The in-flight frame is abandoned and no frame_done is issued.
- Tearing rule: instruction changes mid-frame are invisible until the next frame boundary. Latency from an instruction change to display is at most 8*SCAN_DIV+1 cycles.
- Decode: the code is converted to an active-high pattern gfedcba, then inverted onto seg.
  - 0 = blank 00
  - 1 A 77, 2 b 7C, 3 C 39, 4 d 5E, 5 E 79, 6 F 71, 7 G 3D
  - 8 H 76, 9 I 30, 10 J 1E, 11 K 75, 12 L 38, 13 M 55, 14 n 54
  - 15 O 3F, 16 P 73, 17 q 67, 18 r 50, 19 S 6D, 20 t 78, 21 U 3E
  - 22 v 1C, 23 W 2A, 24 X 49, 25 y 6E, 26 Z 5B
  - 27-31 = '-' 40 (invalid code marker)
- Simultaneous events: if enable falls on the frame-boundary cycle, frame_done still pulses on that cycle and the FSM then goes to IDLE.
- Reset mid-frame: immediate return to the reset values. After reset_n rises, the first snapshot is taken on the first edge with enable=1.
- The counter must be wide enough for SCAN_DIV-1 (use $clog2) and must never exceed SCAN_DIV-1.

Test Plan (SCAN_DIV=8, GUARD_CYCLES=2):
- Reset, then enable=1 with instruction={B,A,L,A,N,C,E,blank} (02,01,0C,01,0E,03,05,00).
  - Slot 7: seg=~7C; an=FF for 2 cycles, then 7F for 6 cycles.
  - Following slots in order: ~77, ~38, ~77, ~54, ~39, ~79, ~00 (=7F).
  - frame_done pulses exactly once at cycle 64.
- Change instruction to all 5'b11111 during slot 4.
  - The current frame still shows BALANCE.
  - The next frame shows seg=~40 ('-' 40 → 3F) on every digit.
- enable dropped during slot 3.
  - Next edge: an=FF, seg=7F, no frame_done.
  - Re-enable: the scan restarts at digit 7 with a fresh snapshot.
- Assert reset_n low asynchronously mid-slot (between clock edges).
  - Outputs go to FF/7F/0 immediately, without waiting for a clock.
  - After release, the block holds IDLE until enable=1.
- enable falls exactly on the frame-boundary edge → frame_done=1 on that cycle, then IDLE.
- Sweep all 32 codes on digit 0 across 32 frames → seg matches the decode table for every code.

Source files
------------

// File: rtl/inst_display_scan.sv
// inst_display_scan
// Time-multiplexes a 40-bit instruction word onto an 8-digit common-anode
// 7-segment display. The word is captured once per frame, so a change in the
// middle of a frame never tears the display.
//
// Ports:
//   sys_clock    system clock, rising edge
//   reset_n      asynchronous active-low reset
//   instruction  eight 5-bit character codes, [39:35] = digit 7 (leftmost)
//   enable       1 = scan the display, 0 = blank it
//   an           digit anodes, active-low, an[7] = leftmost
//   seg          segments {g,f,e,d,c,b,a}, active-low
//   frame_done   one-cycle pulse when the digit-0 slot completes
module inst_display_scan #(
  parameter int SCAN_DIV     = 100000,
  parameter int GUARD_CYCLES = 1000
) (
  input  logic        sys_clock,
  input  logic        reset_n,
  input  logic [39:0] instruction,
  input  logic        enable,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        frame_done
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD    = CNT_W'(GUARD_CYCLES);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       digit_q, digit_d;
  logic [39:0]      snap_q, snap_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             frame_done_q, frame_done_d;
  logic [4:0]       cur_char;

  // Character code to active-high gfedcba pattern; codes 27-31 show '-'.
  function automatic logic [6:0] decode(input logic [4:0] code);
    logic [6:0] p;
    case (code)
      5'd0:  p = 7'h00;
      5'd1:  p = 7'h77;
      5'd2:  p = 7'h7C;
      5'd3:  p = 7'h39;
      5'd4:  p = 7'h5E;
      5'd5:  p = 7'h79;
      5'd6:  p = 7'h71;
      5'd7:  p = 7'h3D;
      5'd8:  p = 7'h76;
      5'd9:  p = 7'h30;
      5'd10: p = 7'h1E;
      5'd11: p = 7'h75;
      5'd12: p = 7'h38;
      5'd13: p = 7'h55;
      5'd14: p = 7'h54;
      5'd15: p = 7'h3F;
      5'd16: p = 7'h73;
      5'd17: p = 7'h67;
      5'd18: p = 7'h50;
      5'd19: p = 7'h6D;
      5'd20: p = 7'h78;
      5'd21: p = 7'h3E;
      5'd22: p = 7'h1C;
      5'd23: p = 7'h2A;
      5'd24: p = 7'h49;
      5'd25: p = 7'h6E;
      5'd26: p = 7'h5B;
      default: p = 7'h40;
    endcase
    return p;
  endfunction

  // Next-state logic. The registered outputs are computed from the *next*
  // counter/digit/snapshot so that an/seg line up with the slot position the
  // counter holds during the same cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    digit_d      = digit_q;
    snap_d       = snap_q;
    an_d         = 8'hFF;
    seg_d        = seg_q;
    frame_done_d = 1'b0;
    cur_char     = 5'd0;

    case (state_q)
      IDLE: begin
        seg_d = 7'h7F;
        cnt_d = '0;
        if (enable) begin
          state_d = SCAN;
          snap_d  = instruction;
          digit_d = 3'd7;
        end
      end
      SCAN: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (digit_q == 3'd0) begin
            // Frame boundary: pulse even if enable is falling on this edge.
            frame_done_d = 1'b1;
            digit_d      = 3'd7;
            snap_d       = instruction;
          end else begin
            digit_d = digit_q - 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = '0;
          digit_d = 3'd7;
          seg_d   = 7'h7F;
        end
      end
      default: begin
        state_d = IDLE;
        seg_d   = 7'h7F;
      end
    endcase

    if (state_d == SCAN) begin
      for (int i = 0; i < 8; i++) begin
        if (digit_d == 3'(i)) cur_char = snap_d[i*5 +: 5];
      end
      if (cnt_d == '0) seg_d = ~decode(cur_char);
      // Guard interval keeps all anodes off while seg settles on the new digit.
      if (cnt_d >= GUARD) an_d = ~(8'd1 << digit_d);
    end
  end

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      digit_q      <= 3'd7;
      snap_q       <= '0;
      an_q         <= 8'hFF;
      seg_q        <= 7'h7F;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      digit_q      <= digit_d;
      snap_q       <= snap_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;

endmodule
